// File: rtl/fir_pkg.sv
// Shared FIR sample definitions used by the core bench, the x-side feeder and the y-side sink.
package fir_pkg;
  localparam int FIR_DATA_W = 32;
  typedef logic signed [FIR_DATA_W-1:0] fir_sample_t;
endpackage

// File: rtl/fir_sync_fifo.sv
// Generic single-clock FIFO, registered occupancy, 1-cycle write-to-read latency.
// Caller must not push when full without a same-cycle pop, nor pop when empty.
module fir_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       level_q;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;
  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);
endmodule

// File: rtl/fir_y_sink.sv
// Captures FIR core results on y_triosy_lz into a FIFO, re-presented as a valid/ready stream.
// Strobe-to-m_valid latency 1 cycle; samples arriving while full without a pop are dropped and counted.
module fir_y_sink
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      y_rsc_dat,
  input  logic                   y_triosy_lz,
  input  logic                   clr_ovf,
  input  logic                   m_ready,
  output logic                   m_valid,
  output logic [DATA_W-1:0]      m_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_cnt
);
  logic              full, empty, push, pop, drop;
  logic [DATA_W-1:0] head;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // A pop frees the slot the same edge, so a full FIFO can still accept.
  assign pop  = m_valid && m_ready;
  assign push = y_triosy_lz && (!full || pop);
  assign drop = y_triosy_lz && full && !pop;

  fir_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (y_rsc_dat),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign m_valid = !empty;
  assign m_data  = m_valid ? head : '0;

  always_comb begin
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (clr_ovf)     cnt_d = CNT_W'(1);
      else if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

  assign overflow = ovf_q;
  assign drop_cnt = cnt_q;
endmodule

// File: tb/tb_fir_y_sink.sv
// Scoreboard bench for fir_y_sink: a default instance plus a CNT_W=2 instance on shared stimulus.
module tb_fir_y_sink;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] y_rsc_dat;
  logic        y_triosy_lz;
  logic        clr_ovf;
  logic        m_ready;

  logic        m_valid, m_valid2;
  logic [31:0] m_data, m_data2;
  logic [3:0]  level, level2;
  logic        overflow, overflow2;
  logic [15:0] drop_cnt;
  logic [1:0]  drop_cnt2;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fir_y_sink dut (
    .clk(clk), .rst(rst), .y_rsc_dat(y_rsc_dat), .y_triosy_lz(y_triosy_lz),
    .clr_ovf(clr_ovf), .m_ready(m_ready), .m_valid(m_valid), .m_data(m_data),
    .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  fir_y_sink #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .y_rsc_dat(y_rsc_dat), .y_triosy_lz(y_triosy_lz),
    .clr_ovf(clr_ovf), .m_ready(m_ready), .m_valid(m_valid2), .m_data(m_data2),
    .level(level2), .overflow(overflow2), .drop_cnt(drop_cnt2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one strobe; accepted samples are queued as expected output.
  task automatic strobe(input logic [31:0] v, input bit accepted);
    y_rsc_dat   = v;
    y_triosy_lz = 1'b1;
    if (accepted) exp_q.push_back(v);
  endtask

  task automatic idle();
    y_triosy_lz = 1'b0;
    y_rsc_dat   = '0;
  endtask

  // Monitor: every handshake must deliver the oldest outstanding sample on both instances.
  always @(negedge clk) begin
    if (rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", m_data, 32'hDEAD_BEEF);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("pop_data", m_data, e);
        chk("pop_data_cnt2", m_data2, e);
      end
    end
  end

  initial begin
    rst = 1'b0; idle(); clr_ovf = 1'b0; m_ready = 1'b0;
    #2;
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_data", m_data, 32'd0);
    chk("rst_level", {28'd0, level}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
    tick(); tick();
    rst = 1'b1;

    // Streaming with m_ready high: level stays at 1.
    m_ready = 1'b1;
    strobe(32'd10, 1'b1); tick();
    chk("lat_valid", {31'd0, m_valid}, 32'd1);
    chk("lat_data", m_data, 32'd10);
    strobe(32'd20, 1'b1); tick();
    chk("stream_lvl_a", {28'd0, level}, 32'd1);
    strobe(32'd30, 1'b1); tick();
    chk("stream_lvl_b", {28'd0, level}, 32'd1);
    strobe(32'd40, 1'b1); tick();
    chk("stream_lvl_c", {28'd0, level}, 32'd1);
    idle(); tick();
    chk("stream_empty", {28'd0, level}, 32'd0);
    chk("stream_drop", {16'd0, drop_cnt}, 32'd0);

    // Fill to full, then one drop.
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      strobe(32'(i), 1'b1); tick();
    end
    chk("full_level", {28'd0, level}, 32'd8);
    strobe(32'd9, 1'b0); tick();
    chk("drop_level", {28'd0, level}, 32'd8);
    chk("drop_ovf", {31'd0, overflow}, 32'd1);
    chk("drop_cnt1", {16'd0, drop_cnt}, 32'd1);
    chk("drop_cnt1_w2", {30'd0, drop_cnt2}, 32'd1);

    // Full with simultaneous pop and push.
    m_ready = 1'b1;
    strobe(32'd99, 1'b1); tick();
    chk("fullpp_level", {28'd0, level}, 32'd8);
    chk("fullpp_drop", {16'd0, drop_cnt}, 32'd1);
    idle();
    for (int i = 0; i < 8; i++) tick();
    chk("drained", {28'd0, level}, 32'd0);

    // Backpressure hold.
    m_ready = 1'b0;
    strobe(32'h14, 1'b1); tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, m_valid}, 32'd1);
      chk("bp_data", m_data, 32'h14);
      tick();
    end
    m_ready = 1'b1; tick();
    m_ready = 1'b0;

    // Clear alone, then saturation on the 2-bit counter.
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("clr_ovf", {31'd0, overflow}, 32'd0);
    chk("clr_cnt", {16'd0, drop_cnt}, 32'd0);
    chk("clr_cnt_w2", {30'd0, drop_cnt2}, 32'd0);
    for (int i = 1; i <= 8; i++) begin
      strobe(32'(100 + i), 1'b1); tick();
    end
    for (int i = 0; i < 5; i++) begin
      strobe(32'(200 + i), 1'b0); tick();
    end
    chk("sat_cnt16", {16'd0, drop_cnt}, 32'd5);
    chk("sat_cnt2", {30'd0, drop_cnt2}, 32'd3);
    chk("sat_ovf2", {31'd0, overflow2}, 32'd1);

    // Clear coincident with a drop: the drop wins.
    clr_ovf = 1'b1; strobe(32'd300, 1'b0); tick();
    clr_ovf = 1'b0; idle();
    chk("clrdrop_cnt", {16'd0, drop_cnt}, 32'd1);
    chk("clrdrop_cnt2", {30'd0, drop_cnt2}, 32'd1);
    chk("clrdrop_ovf", {31'd0, overflow}, 32'd1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("clr2_ovf", {31'd0, overflow}, 32'd0);

    // Asynchronous reset with five samples buffered.
    m_ready = 1'b1;
    tick(); tick(); tick();
    m_ready = 1'b0;
    chk("pre_rst_level", {28'd0, level}, 32'd5);
    #2 rst = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_valid", {31'd0, m_valid}, 32'd0);
    chk("arst_data", m_data, 32'd0);
    chk("arst_level", {28'd0, level}, 32'd0);
    chk("arst_drop", {16'd0, drop_cnt}, 32'd0);
    tick(); tick();
    rst = 1'b1;
    strobe(32'd10, 1'b1); tick();
    idle();
    chk("post_rst_valid", {31'd0, m_valid}, 32'd1);
    chk("post_rst_data", m_data, 32'd10);
    chk("post_rst_drop", {16'd0, drop_cnt}, 32'd0);
    m_ready = 1'b1; tick(); tick();

    chk("scoreboard_left", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
